// File: rtl/fetch_bubble_stage.sv
// Instruction fetch with stage-1/2 register: one instruction per cycle on single-cycle memory.
// A bubble request parks the fetched word in a one-entry skid register and injects a NOP into stage 2.
module fetch_bubble_stage #(
  parameter int              AW       = 8,
  parameter int              DW       = 16,
  parameter logic [DW-1:0]   NOP      = '0,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int              CW       = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          BB,
  input  logic          BR_TAKEN,
  input  logic [AW-1:0] BR_TGT,
  output logic          IM_REQ,
  output logic [AW-1:0] IM_ADDR,
  input  logic          IM_ACK,
  input  logic [DW-1:0] IM_DATA,
  output logic [DW-1:0] IR,
  output logic [AW-1:0] PC2,
  output logic          IR_VALID,
  output logic [CW-1:0] BCNT
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DROP  = 2'd3;

  logic [1:0]    state, state_n;
  logic [AW-1:0] pc, pc_n;
  logic [AW-1:0] drop_addr, drop_addr_n;
  logic [DW-1:0] skid, skid_n;
  logic [AW-1:0] skid_pc, skid_pc_n;
  logic [DW-1:0] ir_n;
  logic [AW-1:0] pc2_n;
  logic          ir_valid_n;

  assign IM_REQ  = (state == FETCH) || (state == DROP);
  assign IM_ADDR = (state == DROP) ? drop_addr : pc;

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    drop_addr_n = drop_addr;
    skid_n      = skid;
    skid_pc_n   = skid_pc;
    ir_n        = NOP;
    pc2_n       = PC2;
    ir_valid_n  = 1'b0;
    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        if (BR_TAKEN) begin
          // An unacked request must still be drained so memory sees a clean handshake.
          pc_n = BR_TGT;
          if (!IM_ACK) begin
            drop_addr_n = pc;
            state_n     = DROP;
          end
        end else if (IM_ACK && !BB) begin
          ir_n       = IM_DATA;
          pc2_n      = pc;
          ir_valid_n = 1'b1;
          pc_n       = pc + 1'b1;
        end else if (IM_ACK) begin
          skid_n    = IM_DATA;
          skid_pc_n = pc;
          pc_n      = pc + 1'b1;
          state_n   = HOLD;
        end
      end
      HOLD: begin
        if (BR_TAKEN) begin
          pc_n    = BR_TGT;
          state_n = FETCH;
        end else if (!BB) begin
          ir_n       = skid;
          pc2_n      = skid_pc;
          ir_valid_n = 1'b1;
          state_n    = FETCH;
        end
      end
      default: begin
        // DROP: a redirect only retargets the PC; the ack still ends the drain.
        if (BR_TAKEN) pc_n = BR_TGT;
        if (IM_ACK) state_n = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop_addr <= '0;
      skid      <= NOP;
      skid_pc   <= '0;
      IR        <= NOP;
      PC2       <= '0;
      IR_VALID  <= 1'b0;
      BCNT      <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      drop_addr <= drop_addr_n;
      skid      <= skid_n;
      skid_pc   <= skid_pc_n;
      IR        <= ir_n;
      PC2       <= pc2_n;
      IR_VALID  <= ir_valid_n;
      if (!ir_valid_n && (BCNT != '1)) BCNT <= BCNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_bubble_stage.sv
// Directed bench for fetch_bubble_stage: latency-programmable memory model plus an issue scoreboard.
module tb_fetch_bubble_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        BB;
  logic        BR_TAKEN;
  logic [7:0]  BR_TGT;
  logic        IM_REQ;
  logic [7:0]  IM_ADDR;
  logic        IM_ACK;
  logic [15:0] IM_DATA;
  logic [15:0] IR;
  logic [7:0]  PC2;
  logic        IR_VALID;
  logic [7:0]  BCNT;

  int checks = 0;
  int errors = 0;
  logic [23:0] sb[$];   // expected {pc2, ir} in issue order
  logic [7:0]  lat;
  logic [7:0]  wcnt;

  fetch_bubble_stage dut (
    .CLK(CLK), .RST(RST), .BB(BB), .BR_TAKEN(BR_TAKEN), .BR_TGT(BR_TGT),
    .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR), .IM_ACK(IM_ACK), .IM_DATA(IM_DATA),
    .IR(IR), .PC2(PC2), .IR_VALID(IR_VALID), .BCNT(BCNT)
  );

  always #5 CLK = ~CLK;

  // Memory acks after the request has waited 'lat' cycles; lat=0 acks in the request cycle.
  always @(posedge CLK or posedge RST) begin
    if (RST) wcnt <= '0;
    else if (IM_REQ && !IM_ACK) wcnt <= wcnt + 8'd1;
    else wcnt <= '0;
  end
  assign IM_ACK  = IM_REQ && (wcnt >= lat);
  assign IM_DATA = 16'h1000 + {8'h00, IM_ADDR};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] pc, input logic [15:0] ir);
    sb.push_back({pc, ir});
  endtask

  task automatic tick();
    logic [23:0] e;
    @(posedge CLK);
    #1;
    if (IR_VALID === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_issue: observed pc2=%0h ir=%0h expected no issue", PC2, IR);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("issue", {8'h00, PC2, IR}, {8'h00, e});
      end
    end
  endtask

  initial begin
    RST = 1'b1; BB = 1'b0; BR_TAKEN = 1'b0; BR_TGT = '0; lat = 8'd0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req", IM_REQ, 0);
    check("rst_ir", IR, 0);
    check("rst_pc2", PC2, 0);
    check("rst_valid", IR_VALID, 0);
    check("rst_bcnt", BCNT, 0);
    RST = 1'b0;

    // Single-cycle memory streaming from the reset PC.
    tick();
    check("first_req", IM_REQ, 1);
    check("first_addr", IM_ADDR, 8'h00);
    check("idle_bcnt", BCNT, 1);
    for (int i = 0; i < 5; i++) push(i[7:0], 16'h1000 + 16'(i));
    repeat (5) tick();
    check("stream_drained", sb.size(), 0);
    check("stream_addr", IM_ADDR, 8'h05);
    check("stream_bcnt", BCNT, 1);

    // Bubble for three cycles while addr 5 is fetched.
    BB = 1'b1;
    tick();
    check("hold_req", IM_REQ, 0);
    repeat (2) tick();
    check("hold_valid", IR_VALID, 0);
    check("hold_ir", IR, 0);
    BB = 1'b0;
    push(8'h05, 16'h1005);
    tick();
    check("skid_drained", sb.size(), 0);
    check("after_hold_addr", IM_ADDR, 8'h06);
    check("hold_bcnt", BCNT, 4);
    push(8'h06, 16'h1006);
    tick();

    // Redirect with ack in the same cycle: acked data for addr 7 is discarded.
    BR_TAKEN = 1'b1; BR_TGT = 8'h03;
    tick();
    BR_TAKEN = 1'b0; lat = 8'd2;
    check("redir_addr", IM_ADDR, 8'h03);
    check("redir_valid", IR_VALID, 0);

    // Redirect during the first wait cycle of addr 3 forces a drain.
    BR_TAKEN = 1'b1; BR_TGT = 8'h40;
    tick();
    BR_TAKEN = 1'b0;
    check("drop_req", IM_REQ, 1);
    check("drop_addr", IM_ADDR, 8'h03);
    tick();
    check("drop_addr_hold", IM_ADDR, 8'h03);
    tick();
    check("drop_exit_addr", IM_ADDR, 8'h40);
    check("drop_exit_valid", IR_VALID, 0);
    push(8'h40, 16'h1040);
    repeat (3) tick();
    check("slow_drained", sb.size(), 0);
    check("slow_bcnt", BCNT, 10);
    lat = 8'd0;

    // Branch and bubble together in HOLD: the parked word for 0x41 is flushed.
    BB = 1'b1;
    tick();
    BR_TAKEN = 1'b1; BR_TGT = 8'hFE;
    tick();
    BR_TAKEN = 1'b0; BB = 1'b0;
    check("flush_addr", IM_ADDR, 8'hFE);
    push(8'hFE, 16'h10FE);
    push(8'hFF, 16'h10FF);
    push(8'h00, 16'h1000);
    repeat (2) tick();
    check("wrap_addr", IM_ADDR, 8'h00);
    tick();
    check("wrap_drained", sb.size(), 0);
    check("flush_bcnt", BCNT, 12);

    // Long bubble saturates the counter.
    BB = 1'b1;
    repeat (301) tick();
    check("bcnt_sat", BCNT, 255);
    BB = 1'b0;
    push(8'h01, 16'h1001);
    tick();
    check("long_drained", sb.size(), 0);
    check("bcnt_sat_hold", BCNT, 255);

    // Asynchronous reset while draining.
    lat = 8'd2;
    BR_TAKEN = 1'b1; BR_TGT = 8'h80;
    tick();
    BR_TAKEN = 1'b0;
    check("drop2_req", IM_REQ, 1);
    check("drop2_addr", IM_ADDR, 8'h02);
    #2;
    RST = 1'b1;
    #1;
    check("async_req", IM_REQ, 0);
    check("async_bcnt", BCNT, 0);
    check("async_ir", IR, 0);
    check("async_valid", IR_VALID, 0);
    check("final_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
